// File: rtl/lspc_pixel_timer_pkg.sv
// Shared constants and types for the LSPC2 pixel timer: MODE field layout and PAL border defaults.
package lspc_pixel_timer_pkg;

    // CPU_DATA bit where the 4-bit MODE field starts on a $3C0006 write
    localparam int MODE_DATA_LSB = 4;

    localparam logic [8:0] STOP_TOP_DEF = 9'h010;
    localparam logic [8:0] STOP_BOT_DEF = 9'h0F0;

    // Packed so that field order matches CPU_DATA[7:4] (MSB first)
    typedef struct packed {
        logic auto_reload;
        logic reload_on_vbl;
        logic reload_on_low;
        logic irq_en;
    } mode_t;

endpackage

// File: rtl/lspc_timer_core.sv
// 32-bit loadable down-counter that parks at zero and reports zero combinationally.
module lspc_timer_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        enable,
    output logic [31:0] count,
    output logic        zero
);

    assign zero = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !zero) begin
            count <= count - 32'd1;
        end
    end

endmodule

// File: rtl/lspc_pixel_timer.sv
// LSPC2 programmable pixel timer: CPU/vblank/auto reload, IRQ pulse on underflow.
// Optional PAL border stop is built when LSPC_TIMER_PAL_STOP_EN is defined.
module lspc_pixel_timer
    import lspc_pixel_timer_pkg::*;
#(
    parameter logic       VMODE    = 1'b0,
    parameter logic [8:0] STOP_TOP = STOP_TOP_DEF,
    parameter logic [8:0] STOP_BOT = STOP_BOT_DEF
) (
    input  logic        CLK_24M,
    input  logic        RESET,
    input  logic        PIX_CE,
    input  logic [15:0] CPU_DATA,
    input  logic        WR_LSPC_MODE,
    input  logic        WR_TIMER_HIGH,
    input  logic        WR_TIMER_LOW,
    input  logic        WR_TIMER_STOP,
    input  logic        VBL_START,
    input  logic [8:0]  RASTER_LINE,
    output logic        TIMER_IRQ,
    output logic [31:0] TIMER_COUNT
);

    mode_t       mode;
    logic [31:0] load_val;
    logic        armed;
    logic        frozen;
    logic        tick;
    logic        expire;
    logic        cpu_reload;
    logic        vbl_reload;
    logic        core_load;
    logic [31:0] core_value;
    logic        zero;

`ifdef LSPC_TIMER_PAL_STOP_EN
    logic stop;

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            stop <= 1'b0;
        end else if (WR_TIMER_STOP) begin
            stop <= CPU_DATA[0];
        end
    end

    assign frozen = VMODE && stop &&
                    ((RASTER_LINE < STOP_TOP) || (RASTER_LINE >= STOP_BOT));
`else
    logic unused_stop;

    assign frozen      = 1'b0;
    assign unused_stop = ^{WR_TIMER_STOP, RASTER_LINE, VMODE, STOP_TOP, STOP_BOT};
`endif

    assign tick       = PIX_CE && !frozen;
    assign expire     = tick && zero && armed;
    assign cpu_reload = WR_TIMER_LOW && mode.reload_on_low;
    assign vbl_reload = VBL_START && mode.reload_on_vbl;

    // Reload source priority: CPU low write, then vblank, then auto reload on expiry
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        core_load  = 1'b1;
        core_value = load_val;
        if (cpu_reload) begin
            core_value = {load_val[31:16], CPU_DATA};
        end else if (vbl_reload) begin
            core_value = load_val;
        end else if (expire && mode.auto_reload) begin
            core_value = load_val;
        end else begin
            core_load = 1'b0;
        end
    end

    // NOTE: reset is synchronous; every control register is cleared, including the pending IRQ.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            mode      <= '0;
            load_val  <= '0;
            armed     <= 1'b0;
            TIMER_IRQ <= 1'b0;
        end else begin
            TIMER_IRQ <= expire && mode.irq_en;
            if (WR_LSPC_MODE)  mode           <= mode_t'(CPU_DATA[MODE_DATA_LSB +: 4]);
            if (WR_TIMER_HIGH) load_val[31:16] <= CPU_DATA;
            if (WR_TIMER_LOW)  load_val[15:0]  <= CPU_DATA;
            // A reload re-arms even when it lands on the expiry edge
            if (cpu_reload || vbl_reload) begin
                armed <= 1'b1;
            end else if (expire && !mode.auto_reload) begin
                armed <= 1'b0;
            end
        end
    end

    lspc_timer_core u_core (
        .clk        (CLK_24M),
        .rst        (RESET),
        .load       (core_load),
        .load_value (core_value),
        .enable     (tick),
        .count      (TIMER_COUNT),
        .zero       (zero)
    );

endmodule
